// File: rtl/pdu_console.sv
// Console front end: debounced buttons/switches, button event FIFO, hex edit register, muxed 7-seg display, IO-bus registers.
// Presses reach the FIFO/edit register 2 clks after the debounced value updates; io_din is combinational from io_addr.
module pdu_console #(
    parameter int N_BTN      = 5,
    parameter int N_SW       = 16,
    parameter int DIGITS     = 8,
    parameter int TICK_DIV   = 65536,
    parameter int DB_CNT     = 16,
    parameter int SCAN_DIV   = 131072,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_BTN-1:0]  btn,
    input  logic [N_SW-1:0]   sw,
    input  logic [7:0]        io_addr,
    input  logic [31:0]       io_dout,
    input  logic              io_we,
    input  logic              io_rd,
    output logic [31:0]       io_din,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic [1:0]        mode_led
);
    localparam int N_IN = N_BTN + N_SW;
    localparam int GN   = N_BTN - 2;
    localparam int TW   = $clog2(TICK_DIV);
    localparam int SCW  = $clog2(SCAN_DIV);
    localparam int CW   = $clog2(DB_CNT + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h3F; 4'h1: font = 7'h06; 4'h2: font = 7'h5B; 4'h3: font = 7'h4F;
            4'h4: font = 7'h66; 4'h5: font = 7'h6D; 4'h6: font = 7'h7D; 4'h7: font = 7'h07;
            4'h8: font = 7'h7F; 4'h9: font = 7'h6F; 4'hA: font = 7'h77; 4'hB: font = 7'h7C;
            4'hC: font = 7'h39; 4'hD: font = 7'h5E; 4'hE: font = 7'h79; default: font = 7'h71;
        endcase
    endfunction

    logic [N_IN-1:0]  sync1_q, sync2_q;
    logic [N_IN-1:0]  stable_q, stable_d, prev_q, prev_d;
    logic             init_q, init_d;
    logic [CW-1:0]    dbc_q [N_IN];
    logic [CW-1:0]    dbc_d [N_IN];
    logic [TW-1:0]    tdiv_q, tdiv_d;
    logic             tick;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_SW-1:0]  sw_diff_q, sw_diff_d;
    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [2:0]       mem_d [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d, blank_q, blank_d;
    logic [31:0]      tmp_q, tmp_d, swx_data_q, swx_data_d, seg_data_q, seg_data_d, cyc_q, cyc_d;
    logic             swx_vld_q, swx_vld_d, seg_rdy_q, seg_rdy_d, out_mode_q, out_mode_d;
    logic [SCW-1:0]   scan_q, scan_d;
    logic [DW-1:0]    digit_q, digit_d, top;

    logic             empty, full, push_req, do_push, multi, edit, sw_one;
    logic             rd_swx, rd_pop, wr_seg, wr_ctl;
    logic [2:0]       push_idx;
    logic [3:0]       sw_idx, nib;
    logic [GN-1:0]    gen;
    logic [31:0]      disp_val;

    // Two-stage synchronizer on the asynchronous pins; no reset needed.
    always_ff @(posedge clk) begin
        sync1_q <= {btn, sw};
        sync2_q <= sync1_q;
    end

    always_comb begin
        tick     = (tdiv_q == TW'(TICK_DIV - 1));
        tdiv_d   = tick ? '0 : tdiv_q + 1'b1;
        stable_d = stable_q;
        init_d   = 1'b0;
        for (int i = 0; i < N_IN; i++) dbc_d[i] = dbc_q[i];
        // First cycle out of reset adopts the pins, so held inputs never look like edges.
        if (init_q) begin
            stable_d = sync2_q;
        end else if (tick) begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (dbc_q[i] == CW'(DB_CNT - 1)) begin
                        stable_d[i] = sync2_q[i];
                        dbc_d[i]    = '0;
                    end else begin
                        dbc_d[i] = dbc_q[i] + 1'b1;
                    end
                end else begin
                    dbc_d[i] = '0;
                end
            end
        end
        prev_d    = init_q ? sync2_q : stable_q;
        press_d   = stable_q[N_IN-1:N_SW] & ~prev_q[N_IN-1:N_SW];
        sw_diff_d = stable_q[N_SW-1:0] ^ prev_q[N_SW-1:0];
    end

    always_comb begin
        rd_swx  = io_rd && (io_addr == 8'h14);
        empty   = (cnt_q == '0);
        full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
        rd_pop  = io_rd && (io_addr == 8'h20) && !empty;
        wr_seg  = io_we && (io_addr == 8'h0C);
        wr_ctl  = io_we && (io_addr == 8'h24);

        gen      = press_q[N_BTN-1:2];
        multi    = |(gen & (gen - GN'(1)));
        push_req = |gen;
        push_idx = 3'd0;
        for (int i = N_BTN - 1; i >= 2; i--) if (press_q[i]) push_idx = 3'(i);
        do_push  = push_req && (!full || rd_pop);

        for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
        if (do_push) mem_d[wr_ptr_q] = push_idx;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(rd_pop);
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(rd_pop);
        ovf_d    = ovf_q;
        if (wr_ctl && io_dout[0]) ovf_d = 1'b0;
        if (multi || (push_req && !do_push)) ovf_d = 1'b1;
        blank_d  = wr_ctl ? io_dout[1] : blank_q;
    end

    always_comb begin
        sw_one = $onehot(sw_diff_q);
        sw_idx = 4'd0;
        for (int i = 0; i < N_SW; i++) if (sw_diff_q[i]) sw_idx = 4'(i);
        tmp_d      = tmp_q;
        swx_data_d = swx_data_q;
        swx_vld_d  = rd_swx ? 1'b0 : swx_vld_q;
        edit       = 1'b0;
        if (sw_one) begin
            tmp_d = {tmp_q[27:0], sw_idx};
            edit  = 1'b1;
        end else if (press_q[0]) begin
            tmp_d = tmp_q >> 4;
            edit  = 1'b1;
        end else if (press_q[1] && !swx_vld_q) begin
            swx_data_d = tmp_q;
            tmp_d      = '0;
            swx_vld_d  = 1'b1;
        end
        seg_data_d = seg_data_q;
        seg_rdy_d  = seg_rdy_q;
        out_mode_d = out_mode_q;
        // A CPU display write overrides an edit landing in the same cycle.
        if (wr_seg) begin
            seg_data_d = io_dout;
            seg_rdy_d  = 1'b0;
            out_mode_d = 1'b1;
        end else if (edit) begin
            seg_rdy_d  = 1'b1;
            out_mode_d = 1'b0;
        end
        cyc_d = cyc_q + 32'd1;
    end

    always_comb begin
        disp_val = out_mode_q ? seg_data_q : tmp_q;
        top      = '0;
        for (int i = 0; i < DIGITS; i++) if (disp_val[4*i +: 4] != 4'h0) top = DW'(i);
        scan_d   = (scan_q == SCW'(SCAN_DIV - 1)) ? '0 : scan_q + 1'b1;
        digit_d  = digit_q;
        if (scan_q == SCW'(SCAN_DIV - 1)) digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
        nib      = disp_val[{digit_q, 2'b00} +: 4];
        an       = '1;
        if (!(blank_q && (digit_q > top))) an[digit_q] = 1'b0;
        seg      = ~font(nib);
        mode_led = out_mode_q ? 2'b01 : 2'b10;
    end

    always_comb begin
        io_din = 32'd0;
        case (io_addr)
            8'h04: io_din = 32'(stable_q);
            8'h08: io_din = {31'd0, seg_rdy_q};
            8'h10: io_din = {31'd0, swx_vld_q};
            8'h14: io_din = swx_data_q;
            8'h18: io_din = cyc_q;
            8'h1C: io_din = {ovf_q, 15'd0, 8'(cnt_q), 7'd0, empty};
            8'h20: io_din = empty ? 32'd0 : {1'b1, 28'd0, mem_q[rd_ptr_q]};
            default: io_din = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stable_q   <= '0;
            prev_q     <= '0;
            init_q     <= 1'b1;
            for (int i = 0; i < N_IN; i++) dbc_q[i] <= '0;
            tdiv_q     <= '0;
            press_q    <= '0;
            sw_diff_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            blank_q    <= 1'b0;
            tmp_q      <= '0;
            swx_data_q <= '0;
            swx_vld_q  <= 1'b0;
            seg_data_q <= 32'h12345678;
            seg_rdy_q  <= 1'b1;
            out_mode_q <= 1'b1;
            cyc_q      <= '0;
            scan_q     <= '0;
            digit_q    <= '0;
        end else begin
            stable_q   <= stable_d;
            prev_q     <= prev_d;
            init_q     <= init_d;
            for (int i = 0; i < N_IN; i++) dbc_q[i] <= dbc_d[i];
            tdiv_q     <= tdiv_d;
            press_q    <= press_d;
            sw_diff_q  <= sw_diff_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            blank_q    <= blank_d;
            tmp_q      <= tmp_d;
            swx_data_q <= swx_data_d;
            swx_vld_q  <= swx_vld_d;
            seg_data_q <= seg_data_d;
            seg_rdy_q  <= seg_rdy_d;
            out_mode_q <= out_mode_d;
            cyc_q      <= cyc_d;
            scan_q     <= scan_d;
            digit_q    <= digit_d;
        end
    end
endmodule

// File: tb/tb_pdu_console.sv
// Directed bench for pdu_console with short debounce/scan dividers.
module tb_pdu_console;
    logic        clk, rstn;
    logic [4:0]  btn;
    logic [15:0] sw;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we, io_rd;
    logic [31:0] io_din;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [1:0]  mode_led;

    int checks = 0;
    int errors = 0;

    pdu_console #(.N_BTN(5), .N_SW(16), .DIGITS(8), .TICK_DIV(4), .DB_CNT(3), .SCAN_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .btn(btn), .sw(sw), .io_addr(io_addr), .io_dout(io_dout),
        .io_we(io_we), .io_rd(io_rd), .io_din(io_din), .an(an), .seg(seg), .mode_led(mode_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(input logic [7:0] a, output logic [31:0] v);
        io_addr = a;
        #1 v = io_din;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        @(negedge clk);
        io_addr = a;
        io_rd   = 1'b1;
        #1 v = io_din;
        @(negedge clk);
        io_rd = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        io_addr = a;
        io_dout = d;
        io_we   = 1'b1;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    task automatic press(input int b);
        @(negedge clk);
        btn[b] = 1'b1;
        idle(30);
        btn[b] = 1'b0;
        idle(30);
    endtask

    task automatic toggle(input int s);
        @(negedge clk);
        sw[s] = ~sw[s];
        idle(30);
    endtask

    // Waits until the cycle counter matches the phase of c0 modulo the tick period.
    task automatic align(input logic [31:0] c0, output bit ok);
        logic [31:0] c;
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1 peek(8'h18, c);
            if (c[1:0] == c0[1:0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, c0;
        logic [7:0]  lit;
        logic [6:0]  segs [8];
        int          lat, dlat;
        bit          ok;

        clk = 0; rstn = 0; btn = '0; sw = '0;
        io_addr = '0; io_dout = '0; io_we = 0; io_rd = 0;
        for (int i = 0; i < 8; i++) segs[i] = 7'h7F;

        // Reset state
        idle(3);
        chk("rst_an", 32'(an), 32'h000000FE);
        chk("rst_seg_digit8", 32'(seg), 32'h00000000);
        chk("rst_mode", 32'(mode_led), 32'h1);
        rstn = 1;
        idle(3);
        peek(8'h18, v); chk("rst_cycles", v, 32'd3);
        peek(8'h08, v); chk("rst_seg_rdy", v, 32'h1);
        peek(8'h1C, v); chk("rst_fifo_stat", v, 32'h00000001);
        peek(8'h10, v); chk("rst_swx_vld", v, 32'h0);
        peek(8'h14, v); chk("rst_swx_data", v, 32'h0);
        peek(8'h04, v); chk("rst_inputs", v, 32'h0);

        // Bounce btn[2] for two ticks only
        @(negedge clk);
        btn[2] = 1'b1;
        idle(8);
        btn[2] = 1'b0;
        idle(30);
        peek(8'h1C, v); chk("bounce_no_event", v, 32'h00000001);

        // Held press; measure raw-to-push latency for later alignment
        peek(8'h18, c0);
        btn[2] = 1'b1;
        io_addr = 8'h1C;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            #1;
            if (io_din[15:8] != 8'h00) begin
                lat = k;
                break;
            end
        end
        chk("press_seen", 32'(lat > 0), 32'h1);
        idle(30);
        btn[2] = 1'b0;
        idle(30);
        peek(8'h1C, v); chk("one_entry", v, 32'h00000100);
        rd(8'h20, v);   chk("entry_btn2", v, 32'h80000002);
        peek(8'h1C, v); chk("drained", v, 32'h00000001);

        // Hex entry: A, 3, del, F -> 0xAF
        toggle(10); toggle(3); press(0); toggle(15);
        press(1);
        peek(8'h10, v); chk("swx_vld_set", v, 32'h1);
        peek(8'h14, v); chk("swx_data_AF", v, 32'h000000AF);
        press(1);
        peek(8'h14, v); chk("second_data_ignored", v, 32'h000000AF);
        rd(8'h14, v);   chk("rd_swx_data", v, 32'h000000AF);
        peek(8'h10, v); chk("swx_vld_cleared", v, 32'h0);
        press(1);
        peek(8'h14, v); chk("tmp_was_cleared", v, 32'h0);
        peek(8'h10, v); chk("swx_vld_again", v, 32'h1);
        rd(8'h14, v);

        // FIFO full: 2,3,4,2 queued, 3 dropped
        press(2); press(3); press(4); press(2); press(3);
        peek(8'h1C, v); chk("full_ovf", v, 32'h80000400);
        align(c0, ok);
        chk("align_pop", 32'(ok), 32'h1);
        btn[4] = 1'b1;
        repeat (lat - 1) @(negedge clk);
        #1 io_addr = 8'h20;
        io_rd = 1'b1;
        #1 v = io_din;
        chk("pop_with_push_head", v, 32'h80000002);
        @(negedge clk);
        #1 io_rd = 1'b0;
        idle(30);
        btn[4] = 1'b0;
        idle(30);
        peek(8'h1C, v); chk("pop_push_full_count", v, 32'h80000400);
        wr(8'h24, 32'h1);
        peek(8'h1C, v); chk("ovf_cleared", v, 32'h00000400);
        rd(8'h20, v); chk("pop1", v, 32'h80000003);
        rd(8'h20, v); chk("pop2", v, 32'h80000004);
        rd(8'h20, v); chk("pop3", v, 32'h80000002);
        rd(8'h20, v); chk("pop4", v, 32'h80000004);
        rd(8'h20, v); chk("pop_empty", v, 32'h0);
        peek(8'h1C, v); chk("empty_after_drain", v, 32'h00000001);

        // Display with leading-zero blanking
        wr(8'h24, 32'h2);
        wr(8'h0C, 32'h00000A05);
        chk("out_mode", 32'(mode_led), 32'h1);
        peek(8'h08, v); chk("seg_rdy_clr", v, 32'h0);
        lit = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            for (int d = 0; d < 8; d++) begin
                if (an[d] === 1'b0) begin
                    lit[d]  = 1'b1;
                    segs[d] = seg;
                end
            end
        end
        chk("lit_digits", 32'(lit), 32'h00000007);
        chk("digit0_5", 32'(segs[0]), 32'h12);
        chk("digit1_0", 32'(segs[1]), 32'h40);
        chk("digit2_A", 32'(segs[2]), 32'h08);
        toggle(5);
        chk("edit_mode", 32'(mode_led), 32'h2);
        peek(8'h08, v); chk("seg_rdy_set", v, 32'h1);

        // Two-bit switch change is ignored; tmp then 5,6,7
        @(negedge clk);
        sw[1] = 1'b1;
        sw[2] = 1'b1;
        idle(30);
        toggle(6); toggle(7);

        // Measure del latency through the mode LED
        wr(8'h0C, 32'h0);
        peek(8'h18, c0);
        btn[0] = 1'b1;
        dlat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            #1;
            if (mode_led == 2'b10) begin
                dlat = k;
                break;
            end
        end
        chk("del_seen", 32'(dlat > 0), 32'h1);
        idle(30);
        btn[0] = 1'b0;
        idle(30);

        // Second del coincides with a display write
        wr(8'h0C, 32'h0);
        align(c0, ok);
        chk("align_del", 32'(ok), 32'h1);
        btn[0] = 1'b1;
        repeat (dlat - 1) @(negedge clk);
        #1 io_addr = 8'h0C;
        io_dout = 32'h00001234;
        io_we   = 1'b1;
        @(negedge clk);
        #1 io_we = 1'b0;
        chk("write_beats_del", 32'(mode_led), 32'h1);
        idle(30);
        btn[0] = 1'b0;
        idle(30);
        chk("still_out_mode", 32'(mode_led), 32'h1);
        peek(8'h08, v); chk("seg_rdy_after_tie", v, 32'h0);
        press(1);
        peek(8'h14, v); chk("tmp_after_dels", v, 32'h00000005);
        rd(8'h14, v);

        // Reset with a queued event and a press mid-debounce
        press(3);
        peek(8'h1C, v); chk("queued_before_rst", v, 32'h00000100);
        @(negedge clk);
        btn[2] = 1'b1;
        idle(10);
        rstn = 1'b0;
        idle(2);
        chk("midrst_an", 32'(an), 32'h000000FE);
        chk("midrst_mode", 32'(mode_led), 32'h1);
        rstn = 1'b1;
        idle(3);
        peek(8'h18, v); chk("midrst_cycles", v, 32'd3);
        peek(8'h1C, v); chk("midrst_fifo", v, 32'h00000001);
        peek(8'h08, v); chk("midrst_seg_rdy", v, 32'h1);
        peek(8'h10, v); chk("midrst_swx_vld", v, 32'h0);
        peek(8'h04, v); chk("midrst_inputs", v, 32'({btn, sw}));
        idle(30);
        btn[2] = 1'b0;
        idle(30);
        peek(8'h1C, v); chk("no_spurious_press", v, 32'h00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
